// File: rtl/uart_tx_dev.sv
// ---------------------------------------------------------------------------
// uart_tx_dev
// Memory-mapped UART transmitter that sits on the device side of the bridge,
// next to the timer devices, and shares their bus shape. Written bytes are
// queued in a small FIFO and sent as 8N1 frames on txd. IRQ is raised once the
// transmitter has fully drained.
//
// Ports
//   clk    system clock
//   reset  synchronous, active-high reset
//   Addr   word address; only Addr[1:0] selects a register here
//   WE     write strobe, one cycle per write
//   Din    write data
//   Dout   read data, combinational from Addr
//   IRQ    registered level interrupt
//   txd    registered serial output, idle high
//
// Register map (Addr[1:0])
//   0 CTRL   rw  bit0 EN, bit1 IE; any write clears OVF
//   1 DIV    rw  clock cycles per bit (0 behaves as 1)
//   2 TXDATA wo  push Din[7:0]; reads as 0
//   3 STATUS ro  bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 OVF, bits[7:4] count
// ---------------------------------------------------------------------------
module uart_tx_dev #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        txd
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_t;

   txState_t             r_state;
   logic                 r_en;
   logic                 r_ie;
   logic                 r_ovf;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_bcnt;
   logic [2:0]           r_idx;
   logic [7:0]           r_shreg;
   logic                 r_txd;
   logic                 r_irq;
   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;

   logic                 w_wrCtrl;
   logic                 w_wrDiv;
   logic                 w_wrData;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_busy;
   logic                 w_bitEnd;
   logic                 w_startOk;
   logic                 w_pop;
   logic                 w_pushOk;
   logic                 w_push;
   logic                 w_nextIdle;
   logic [DIV_WIDTH-1:0] w_divEff;
   logic [DIV_WIDTH-1:0] w_reload;
   logic [2:0]           w_nextIdx;
   logic [7:0]           w_head;
   logic [31:0]          w_countExt;
   logic                 w_unused;

   // Bus decode and FIFO status. A pop on the same edge frees a slot, so a
   // push into a full FIFO is still accepted when the FSM is popping.
   assign w_wrCtrl   = WE && (Addr[1:0] == 2'd0);
   assign w_wrDiv    = WE && (Addr[1:0] == 2'd1);
   assign w_wrData   = WE && (Addr[1:0] == 2'd2);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_busy     = (r_state != IDLE);
   assign w_bitEnd   = (r_bcnt == '0);
   assign w_startOk  = r_en && !w_empty;
   assign w_pop      = w_startOk && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));
   assign w_pushOk   = !w_full || w_pop;
   assign w_push     = w_wrData && w_pushOk;
   assign w_nextIdle = ((r_state == IDLE) && !w_startOk) ||
                       ((r_state == STOP) && w_bitEnd && !w_startOk);
   assign w_divEff   = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
   assign w_reload   = w_divEff - DIV_WIDTH'(1);
   assign w_nextIdx  = r_idx + 3'd1;
   assign w_head     = r_mem[r_rptr];
   assign w_countExt = 32'(r_count);
   assign w_unused   = ^{Addr[29:2], Din, w_countExt[31:4]};

   assign txd = r_txd;
   assign IRQ = r_irq;

   // Read mux; unmapped bits read as zero.
   always_comb begin
      Dout = '0;
      case (Addr[1:0])
         2'd0: Dout[1:0] = {r_ie, r_en};
         2'd1: Dout[DIV_WIDTH-1:0] = r_div;
         2'd2: Dout = '0;
         2'd3: Dout[7:0] = {w_countExt[3:0], r_ovf, w_empty, w_full, w_busy};
         default: Dout = '0;
      endcase
   end

   // Control registers, overflow flag and FIFO pointers/occupancy. A rejected
   // push sets OVF; only a CTRL write clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en    <= 1'b0;
         r_ie    <= 1'b0;
         r_ovf   <= 1'b0;
         r_div   <= DIV_WIDTH'(16);
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wrCtrl) begin
            r_en  <= Din[0];
            r_ie  <= Din[1];
            r_ovf <= 1'b0;
         end
         if (w_wrDiv) begin
            r_div <= Din[DIV_WIDTH-1:0];
         end
         if (w_wrData && !w_pushOk) begin
            r_ovf <= 1'b1;
         end
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= Din[7:0];
      end
   end

   // Transmit FSM. Every bit (start, data, stop) lasts DIV cycles: the bit
   // counter is loaded with DIV-1 at the start of a bit and the bit ends when
   // it reaches zero. The reload reads DIV at that moment, so a DIV write
   // mid-bit only shapes later bits. Leaving STOP with more data queued goes
   // straight to START so frames run back to back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_txd   <= 1'b1;
         r_bcnt  <= '0;
         r_idx   <= 3'd0;
         r_shreg <= 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_startOk) begin
                  r_shreg <= w_head;
                  r_txd   <= 1'b0;
                  r_bcnt  <= w_reload;
                  r_state <= START;
               end else begin
                  r_txd <= 1'b1;
               end
            end
            START: begin
               if (w_bitEnd) begin
                  r_txd   <= r_shreg[0];
                  r_idx   <= 3'd0;
                  r_bcnt  <= w_reload;
                  r_state <= DATA;
               end else begin
                  r_bcnt <= r_bcnt - DIV_WIDTH'(1);
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  r_bcnt <= w_reload;
                  if (r_idx == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_idx <= w_nextIdx;
                     r_txd <= r_shreg[w_nextIdx];
                  end
               end else begin
                  r_bcnt <= r_bcnt - DIV_WIDTH'(1);
               end
            end
            STOP: begin
               if (w_bitEnd) begin
                  if (w_startOk) begin
                     r_shreg <= w_head;
                     r_txd   <= 1'b0;
                     r_bcnt  <= w_reload;
                     r_state <= START;
                  end else begin
                     r_txd   <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_bcnt <= r_bcnt - DIV_WIDTH'(1);
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Drained interrupt: enabled, nothing queued and the FSM heading to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_ie && w_empty && w_nextIdle;
      end
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_dev
// Directed bench for uart_tx_dev: register reset values, frame shapes at
// several divisors, FIFO overflow and full+pop acceptance, back-to-back
// frames, drained interrupt, mid-bit divisor change and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_dev;

   logic        clk;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        txd;

   int vecCount  = 0;
   int missCount = 0;

   uart_tx_dev #(
      .FIFO_DEPTH(4),
      .DIV_WIDTH (16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ),
      .txd  (txd)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: sim time exceeded, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus write; the register updates on the posedge inside this task
   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Din  = 32'd0;
   endtask

   // Combinational register read
   task automatic readReg(input logic [1:0] a, output logic [31:0] d);
      Addr = {28'd0, a};
      #1;
      d = Dout;
   endtask

   // Sample txd and IRQ on n consecutive falling edges
   task automatic captureTxd(input int n, output logic [63:0] bits, output logic [63:0] irqs);
      bits = '0;
      irqs = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bits[i] = txd;
         irqs[i] = IRQ;
      end
   endtask

   // Expected 8N1 waveform, one entry per clock, for a constant divisor
   function automatic logic [63:0] frameBits(input logic [7:0] b, input int div);
      logic [63:0] r;
      int          slot;
      r = '0;
      for (int k = 0; k < 10 * div; k++) begin
         slot = k / div;
         if (slot == 0)      r[k] = 1'b0;
         else if (slot == 9) r[k] = 1'b1;
         else                r[k] = b[slot-1];
      end
      return r;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [63:0] bits;
      logic [63:0] irqs;
      logic [63:0] exp;
      logic [63:0] one;
      int          dur [10];
      int          pos;
      logic [7:0]  b6;

      reset = 1'b1;
      Addr  = 30'd0;
      WE    = 1'b0;
      Din   = 32'd0;

      // ---- reset values ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      readReg(2'd0, rd); checkOutput("reset CTRL",   64'(rd), 64'h0);
      readReg(2'd1, rd); checkOutput("reset DIV",    64'(rd), 64'd16);
      readReg(2'd2, rd); checkOutput("reset TXDATA", 64'(rd), 64'h0);
      readReg(2'd3, rd); checkOutput("reset STATUS", 64'(rd), 64'h04);
      checkOutput("reset txd", 64'(txd), 64'h1);
      checkOutput("reset IRQ", 64'(IRQ), 64'h0);

      // ---- single frame, DIV=4, byte 0x55 ----
      applyStimulus(2'd1, 32'd4);
      applyStimulus(2'd0, 32'd1);
      readReg(2'd0, rd); checkOutput("CTRL readback", 64'(rd), 64'h1);
      readReg(2'd1, rd); checkOutput("DIV readback",  64'(rd), 64'd4);
      applyStimulus(2'd2, 32'h55);
      @(negedge clk);
      checkOutput("0x55 idle before start", 64'(txd), 64'h1);
      captureTxd(40, bits, irqs);
      checkOutput("0x55 frame", bits, frameBits(8'h55, 4));
      checkOutput("0x55 irq quiet", irqs, 64'h0);
      readReg(2'd3, rd); checkOutput("0x55 busy in stop", 64'(rd), 64'h05);
      @(negedge clk);
      readReg(2'd3, rd); checkOutput("0x55 busy cleared", 64'(rd), 64'h04);

      // ---- overflow with EN=0, then full+pop push and back-to-back frames ----
      applyStimulus(2'd0, 32'd0);
      applyStimulus(2'd1, 32'd1);
      for (int i = 1; i <= 5; i++) applyStimulus(2'd2, 32'(i));
      readReg(2'd3, rd); checkOutput("fifo full+ovf", 64'(rd), 64'h4A);
      applyStimulus(2'd0, 32'd1);
      readReg(2'd3, rd); checkOutput("ctrl clears ovf", 64'(rd), 64'h42);
      applyStimulus(2'd2, 32'h06);
      captureTxd(50, bits, irqs);
      exp = '0;
      for (int f = 0; f < 5; f++) begin
         b6  = (f == 4) ? 8'h06 : 8'(f + 1);
         one = frameBits(b6, 1);
         exp[f*10 +: 10] = one[9:0];
      end
      checkOutput("5 b2b frames DIV=1", bits, exp);
      readReg(2'd3, rd); checkOutput("b2b last stop", 64'(rd), 64'h05);
      @(negedge clk);
      readReg(2'd3, rd); checkOutput("b2b drained", 64'(rd), 64'h04);

      // ---- drained interrupt, DIV=2 ----
      applyStimulus(2'd1, 32'd2);
      applyStimulus(2'd2, 32'hA3);
      applyStimulus(2'd0, 32'd3);
      captureTxd(20, bits, irqs);
      checkOutput("0xA3 frame", bits, frameBits(8'hA3, 2));
      checkOutput("0xA3 irq low in frame", irqs, 64'h0);
      @(negedge clk);
      checkOutput("irq after drain", 64'(IRQ), 64'h1);
      readReg(2'd3, rd); checkOutput("irq status", 64'(rd), 64'h04);
      applyStimulus(2'd2, 32'h3C);
      @(negedge clk);
      checkOutput("0x3C idle before start", 64'(txd), 64'h1);
      captureTxd(20, bits, irqs);
      checkOutput("0x3C frame", bits, frameBits(8'h3C, 2));
      checkOutput("irq dropped by push", irqs, 64'h0);
      @(negedge clk);
      checkOutput("irq after second drain", 64'(IRQ), 64'h1);
      applyStimulus(2'd0, 32'd1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("irq dropped by IE clear", 64'(IRQ), 64'h0);

      // ---- DIV change mid-bit: DIV=8, rewritten to 2 during bit 2 ----
      applyStimulus(2'd1, 32'd8);
      applyStimulus(2'd2, 32'hB4);
      @(negedge clk);
      checkOutput("0xB4 idle before start", 64'(txd), 64'h1);
      fork
         captureTxd(44, bits, irqs);
         begin
            repeat (26) @(posedge clk);
            applyStimulus(2'd1, 32'd2);
         end
      join
      dur = '{8, 8, 8, 8, 2, 2, 2, 2, 2, 2};
      exp = '0;
      pos = 0;
      for (int s = 0; s < 10; s++) begin
         for (int c = 0; c < dur[s]; c++) begin
            if (s == 0)      exp[pos] = 1'b0;
            else if (s == 9) exp[pos] = 1'b1;
            else             exp[pos] = b6IsSet(8'hB4, s - 1);
            pos++;
         end
      end
      checkOutput("DIV change mid-bit", bits, exp);
      @(negedge clk);
      readReg(2'd3, rd); checkOutput("div-change drained", 64'(rd), 64'h04);
      readReg(2'd1, rd); checkOutput("DIV now 2", 64'(rd), 64'd2);

      // ---- reset during DATA bit 3 (DIV=2, byte 0x07 so bit3 is 0) ----
      applyStimulus(2'd2, 32'h07);
      applyStimulus(2'd2, 32'hF0);
      repeat (8) @(posedge clk);
      @(negedge clk);
      checkOutput("bit3 before reset", 64'(txd), 64'h0);
      readReg(2'd3, rd); checkOutput("busy with queued byte", 64'(rd), 64'h11);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("txd after reset", 64'(txd), 64'h1);
      readReg(2'd3, rd); checkOutput("status after reset", 64'(rd), 64'h04);
      checkOutput("irq after reset", 64'(IRQ), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      readReg(2'd0, rd); checkOutput("CTRL after reset", 64'(rd), 64'h0);
      readReg(2'd1, rd); checkOutput("DIV after reset",  64'(rd), 64'd16);
      captureTxd(30, bits, irqs);
      checkOutput("no frame after reset", bits, 64'h3FFF_FFFF);
      readReg(2'd3, rd); checkOutput("still empty after reset", 64'(rd), 64'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   // Bit i of a byte
   function automatic logic b6IsSet(input logic [7:0] b, input int i);
      return b[i];
   endfunction

endmodule
